ex_stage_mdu: RTL and testbench
===============================

Name: ex_stage_mdu

Overview:
- Parametrised successor of the execute stage.
- Combines operand forwarding, ASel/BSel muxing and the single-cycle ALU with an iterative RV32M/RV64M multiply/divide unit (MDU).
- Adds valid tracking, back-pressure (stall in/out) and flush, feeding a stallable EX/MA register.
- Sits between the ID/EX register and memory access; the hazard unit consumes stall_out.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- REGW, 5, register-address width.
- MDU_EN, 1, 0 removes the MDU; md_en_in is then ignored and ops complete as ALU ops.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- valid_in  in  1  ID/EX holds a live instruction.
- pc_in, pcPlus4_in, DataA_in, DataB_in, imm_in  in  XLEN each  ID/EX operands.
- fwd_ma_in, fwd_wb_in  in  XLEN each  forwarded MA/WB results.
- hazardSelA, hazardSelB  in  2 each  forwarding select: 0 = reg, 1 = MA, 2 = WB, 3 = reg.
- AddrD_in  in  REGW  destination register.
- RegWEn_in, ASel_in, BSel_in, MemRW_in  in  1 each  controls.
- ALUSel_in  in  4  ALU op.
- WBSel_in  in  2  writeback select.
- funct3_in  in  3  memory size / MDU op.
- md_en_in  in  1  instruction is an M-extension op.
- flush_in  in  1  kill the instruction in EX.
- stall_in  in  1  downstream hold.
- stall_out  out  1  EX busy; upstream must hold ID/EX.
- valid_out, RegWEn_out, MemRW_out  out  1 each.
- WBSel_out  out  2.
- funct3_out  out  3.
- AddrD_out  out  REGW.
- Result_out, DataB_out, pcPlus4_out  out  XLEN each.

Behaviour:
- Reset: all outputs 0, MDU FSM in IDLE, stall_out 0.
- Forwarding
  - fwdA/fwdB are selected by hazardSelA/B.
  - ALU A = ASel ? pc : fwdA.
  - ALU B = BSel ? imm : fwdB.
  - DataB_out always carries fwdB.
- Non-MDU op (valid_in & !md_en_in): 1-cycle latency; EX/MA captures on the next edge when stall_in = 0.
- MDU FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when valid_in & md_en_in & !flush_in. On entry, latch fwdA, fwdB, funct3 and all control fields, because forwarding sources move while EX is stalled.
  - RUN lasts exactly XLEN cycles: radix-2 shift-add multiply or restoring divide on magnitudes, with the sign fixed up in DONE.
  - RUN→DONE after XLEN cycles.
  - DONE→IDLE when stall_in = 0; the result is captured into EX/MA on that edge.
  - stall_out = 1 in the issue cycle and all RUN cycles; 0 in DONE.
  - Total issue-to-valid_out latency is XLEN+2 cycles when stall_in = 0.
- funct3 op mapping:
  - 0 MUL: low XLEN bits.
  - 1 MULH: signed×signed, high half.
  - 2 MULHSU: signed×unsigned, high half.
  - 3 MULHU: high half.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Divide corner cases:
  - Divide by zero: quotient all-ones; remainder = dividend (signed and unsigned).
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder 0. Early-complete is allowed but not required; the latency rule still holds.
- stall_in = 1: EX/MA holds every output. stall_out is forced to 1 so ID/EX holds. An MDU in DONE waits.
- flush_in = 1:
  - EX/MA captures a bubble: valid_out, RegWEn_out and MemRW_out = 0; other fields don't-care but held.
  - An MDU in RUN/DONE aborts to IDLE next cycle, and stall_out drops combinationally.
  - flush beats stall_in and beats a new MDU issue.
- valid_in = 0 issues a bubble (RegWEn_out = 0, MemRW_out = 0).
- Reset asserted mid-RUN: immediate return to IDLE and all outputs 0.

Decomposition:
- Shared package holds:
  - MDU funct3 constants.
  - Forward-select encodings FWD_REG/FWD_MA/FWD_WB.
  - MDU state enum.
  - WBSel encodings.
- Sub-module ex_muldiv_iter (XLEN parameter) contains the FSM, operand latches, accumulator/partial-remainder registers and a cycle counter of width $clog2(XLEN)+1.
- The existing ALU and mux cells are reused unchanged.

Test Plan:
- Forwarding: DataA = 5, fwd_ma = 7, hazardSelA = 1, ADD with BSel imm = 3 → next cycle Result_out = 10, valid_out = 1.
- MUL/MULH: XLEN = 32, MUL 0xFFFFFFFF×0xFFFFFFFF → stall_out high for 33 cycles, Result_out = 1. MULHU on the same operands = 0xFFFFFFFE; MULH = 0.
- Divide corners: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM = 0. DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Late forward change: issue DIV 100/7 with operands from fwd_wb, then change fwd_wb mid-RUN → result still 14; REM = 2.
- Flush mid-RUN at cycle 10 → stall_out 0 next cycle, valid_out 0, RegWEn_out 0. A following ADD completes normally.
- Stall/reset: stall_in held 3 cycles at DONE → outputs stable, then released once. Reset at RUN cycle 5 → all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/ex_stage_mdu_pkg.sv
// Shared encodings for the execute stage: forwarding selects, ALU ops,
// MDU funct3 ops, writeback selects and the MDU state enum.
package ex_stage_mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MA  = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M/RV64M unit: XLEN-cycle shift-add multiply or restoring
// divide on operand magnitudes; signs and divide-by-zero fixed on the output.
module ex_muldiv_iter
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            ack,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output mdu_state_e      state,
  output logic            busy,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;

  mdu_state_e        state_nxt;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   hi, lo, opb, a_orig;
  logic [2:0]        op_q;
  logic              neg_q, neg_r, div0;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  // Only MULH/MULHSU/DIV/REM treat A as signed; only MULH/DIV/REM treat B so.
  always_comb begin
    a_neg = a[XLEN-1] & ((op == F3_MULH) | (op == F3_MULHSU) | (op == F3_DIV) | (op == F3_REM));
    b_neg = b[XLEN-1] & ((op == F3_MULH) | (op == F3_DIV) | (op == F3_REM));
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = MDU_IDLE;
    else begin
      case (state)
        MDU_IDLE: if (start) state_nxt = MDU_RUN;
        MDU_RUN:  if (cnt == CW'(XLEN - 1)) state_nxt = MDU_DONE;
        MDU_DONE: if (ack) state_nxt = MDU_IDLE;
        default:  state_nxt = MDU_IDLE;
      endcase
    end
  end

  always_comb busy = (state == MDU_RUN);

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
  end

  // hi = accumulator / partial remainder, lo = multiplier / quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; hi <= '0; lo <= '0; opb <= '0; a_orig <= '0;
      op_q <= '0; neg_q <= 1'b0; neg_r <= 1'b0; div0 <= 1'b0;
    end else if (state == MDU_IDLE && start && !abort) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= a_mag;
      opb    <= b_mag;
      a_orig <= a;
      op_q   <= op;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      div0   <= (b == '0);
    end else if (state == MDU_RUN) begin
      cnt <= cnt + CW'(1);
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          hi <= div_diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_shift[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = {hi, lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo : lo;
    rem = neg_r ? -hi : hi;
    if (div0) begin
      quo = '1;
      rem = a_orig;
    end
    case (op_q)
      F3_MUL:                       result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, A/B muxing, single-cycle ALU and an
// iterative MDU, feeding a stallable/flushable EX/MA register.
module ex_stage_mdu
  import ex_stage_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int MDU_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pcPlus4_in,
  input  logic [XLEN-1:0] DataA_in,
  input  logic [XLEN-1:0] DataB_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] fwd_ma_in,
  input  logic [XLEN-1:0] fwd_wb_in,
  input  logic [1:0]      hazardSelA,
  input  logic [1:0]      hazardSelB,
  input  logic [REGW-1:0] AddrD_in,
  input  logic            RegWEn_in,
  input  logic            ASel_in,
  input  logic            BSel_in,
  input  logic            MemRW_in,
  input  logic [3:0]      ALUSel_in,
  input  logic [1:0]      WBSel_in,
  input  logic [2:0]      funct3_in,
  input  logic            md_en_in,
  input  logic            flush_in,
  input  logic            stall_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic            RegWEn_out,
  output logic            MemRW_out,
  output logic [1:0]      WBSel_out,
  output logic [2:0]      funct3_out,
  output logic [REGW-1:0] AddrD_out,
  output logic [XLEN-1:0] Result_out,
  output logic [XLEN-1:0] DataB_out,
  output logic [XLEN-1:0] pcPlus4_out
);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res, mdu_result;
  logic            md_issue, mdu_start, mdu_hold, mdu_busy;
  mdu_state_e      mdu_state;
  logic [REGW-1:0] l_addr;
  logic            l_regwen, l_memrw;
  logic [1:0]      l_wbsel;
  logic [2:0]      l_f3;
  logic [XLEN-1:0] l_pc4, l_datab;

  always_comb begin
    case (hazardSelA)
      FWD_MA:  fwd_a = fwd_ma_in;
      FWD_WB:  fwd_a = fwd_wb_in;
      default: fwd_a = DataA_in;
    endcase
    case (hazardSelB)
      FWD_MA:  fwd_b = fwd_ma_in;
      FWD_WB:  fwd_b = fwd_wb_in;
      default: fwd_b = DataB_in;
    endcase
    alu_a = ASel_in ? pc_in : fwd_a;
    alu_b = BSel_in ? imm_in : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (ALUSel_in)
      ALU_ADD:   alu_res = alu_a + alu_b;
      ALU_SUB:   alu_res = alu_a - alu_b;
      ALU_SLL:   alu_res = alu_a << alu_b[SW-1:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:   alu_res = alu_a ^ alu_b;
      ALU_SRL:   alu_res = alu_a >> alu_b[SW-1:0];
      ALU_SRA:   alu_res = $unsigned($signed(alu_a) >>> alu_b[SW-1:0]);
      ALU_OR:    alu_res = alu_a | alu_b;
      ALU_AND:   alu_res = alu_a & alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase
  end

  // Hold ID/EX from the issue cycle through RUN; DONE lets it advance.
  assign md_issue  = valid_in & md_en_in & (MDU_EN != 0);
  assign mdu_start = md_issue & ~flush_in & (mdu_state == MDU_IDLE);
  assign mdu_hold  = (md_issue & (mdu_state == MDU_IDLE)) | mdu_busy;
  assign stall_out = ~reset & ~flush_in & (stall_in | mdu_hold);

  generate
    if (MDU_EN != 0) begin : gen_mdu
      ex_muldiv_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (reset),
        .start  (mdu_start),
        .abort  (flush_in),
        .ack    (~stall_in),
        .op     (funct3_in),
        .a      (fwd_a),
        .b      (fwd_b),
        .state  (mdu_state),
        .busy   (mdu_busy),
        .result (mdu_result)
      );
    end else begin : gen_no_mdu
      assign mdu_state  = MDU_IDLE;
      assign mdu_busy   = 1'b0;
      assign mdu_result = '0;
    end
  endgenerate

  // Forwarding sources move while EX stalls, so the MDU op's fields are frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_addr <= '0; l_regwen <= 1'b0; l_memrw <= 1'b0; l_wbsel <= '0;
      l_f3 <= '0; l_pc4 <= '0; l_datab <= '0;
    end else if (mdu_start) begin
      l_addr <= AddrD_in; l_regwen <= RegWEn_in; l_memrw <= MemRW_in; l_wbsel <= WBSel_in;
      l_f3 <= funct3_in; l_pc4 <= pcPlus4_in; l_datab <= fwd_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0; RegWEn_out <= 1'b0; MemRW_out <= 1'b0; WBSel_out <= '0;
      funct3_out <= '0; AddrD_out <= '0; Result_out <= '0; DataB_out <= '0; pcPlus4_out <= '0;
    end else if (flush_in) begin
      valid_out <= 1'b0; RegWEn_out <= 1'b0; MemRW_out <= 1'b0;
    end else if (!stall_in) begin
      if (mdu_state == MDU_DONE) begin
        valid_out <= 1'b1; RegWEn_out <= l_regwen; MemRW_out <= l_memrw; WBSel_out <= l_wbsel;
        funct3_out <= l_f3; AddrD_out <= l_addr; Result_out <= mdu_result;
        DataB_out <= l_datab; pcPlus4_out <= l_pc4;
      end else if (mdu_hold) begin
        valid_out <= 1'b0; RegWEn_out <= 1'b0; MemRW_out <= 1'b0;
      end else begin
        valid_out <= valid_in; RegWEn_out <= valid_in & RegWEn_in; MemRW_out <= valid_in & MemRW_in;
        WBSel_out <= WBSel_in; funct3_out <= funct3_in; AddrD_out <= AddrD_in;
        Result_out <= alu_res; DataB_out <= fwd_b; pcPlus4_out <= pcPlus4_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu (XLEN=32): forwarding, MDU ops and corner
// cases, flush, stall and mid-run reset, checked against hand-computed values.
module tb_ex_stage_mdu;
  import ex_stage_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pc_in, pcPlus4_in, DataA_in, DataB_in, imm_in, fwd_ma_in, fwd_wb_in;
  logic [1:0]  hazardSelA, hazardSelB;
  logic [4:0]  AddrD_in;
  logic        RegWEn_in, ASel_in, BSel_in, MemRW_in;
  logic [3:0]  ALUSel_in;
  logic [1:0]  WBSel_in;
  logic [2:0]  funct3_in;
  logic        md_en_in, flush_in, stall_in;
  logic        stall_out, valid_out, RegWEn_out, MemRW_out;
  logic [1:0]  WBSel_out;
  logic [2:0]  funct3_out;
  logic [4:0]  AddrD_out;
  logic [31:0] Result_out, DataB_out, pcPlus4_out;

  int vectors = 0;
  int miscompares = 0;

  ex_stage_mdu #(.XLEN(32), .REGW(5), .MDU_EN(1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .pc_in(pc_in), .pcPlus4_in(pcPlus4_in), .DataA_in(DataA_in), .DataB_in(DataB_in),
    .imm_in(imm_in), .fwd_ma_in(fwd_ma_in), .fwd_wb_in(fwd_wb_in),
    .hazardSelA(hazardSelA), .hazardSelB(hazardSelB), .AddrD_in(AddrD_in),
    .RegWEn_in(RegWEn_in), .ASel_in(ASel_in), .BSel_in(BSel_in), .MemRW_in(MemRW_in),
    .ALUSel_in(ALUSel_in), .WBSel_in(WBSel_in), .funct3_in(funct3_in), .md_en_in(md_en_in),
    .flush_in(flush_in), .stall_in(stall_in), .stall_out(stall_out), .valid_out(valid_out),
    .RegWEn_out(RegWEn_out), .MemRW_out(MemRW_out), .WBSel_out(WBSel_out),
    .funct3_out(funct3_out), .AddrD_out(AddrD_out), .Result_out(Result_out),
    .DataB_out(DataB_out), .pcPlus4_out(pcPlus4_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in = 0; md_en_in = 0; flush_in = 0;
    pc_in = '0; pcPlus4_in = '0; DataA_in = '0; DataB_in = '0; imm_in = '0;
    fwd_ma_in = '0; fwd_wb_in = '0; hazardSelA = FWD_REG; hazardSelB = FWD_REG;
    AddrD_in = '0; RegWEn_in = 0; ASel_in = 0; BSel_in = 0; MemRW_in = 0;
    ALUSel_in = ALU_ADD; WBSel_in = WB_ALU; funct3_in = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an MDU op, count stalled cycles, then check the captured result.
  // With perturb set, operands come from fwd_wb/fwd_ma and are changed mid-RUN.
  task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit perturb);
    int n;
    valid_in = 1; md_en_in = 1; funct3_in = f3; RegWEn_in = 1; AddrD_in = 5'd9;
    ASel_in = 0; BSel_in = 0; WBSel_in = WB_ALU;
    if (perturb) begin
      hazardSelA = FWD_WB; hazardSelB = FWD_MA; fwd_wb_in = a; fwd_ma_in = b;
      DataA_in = 32'h1111_1111; DataB_in = 32'h2222_2222;
    end else begin
      hazardSelA = FWD_REG; hazardSelB = FWD_REG; DataA_in = a; DataB_in = b;
    end
    #1;
    check({tag, "_issue_stall"}, 64'(stall_out), 64'd1);
    n = 0;
    while (stall_out === 1'b1 && n < 100) begin
      tick();
      n++;
      if (perturb && n == 10) begin
        check({tag, "_run_valid"}, 64'(valid_out), 64'd0);
        fwd_wb_in = 32'hDEAD_BEEF; fwd_ma_in = 32'd3; #1;
      end
    end
    check({tag, "_stall_cycles"}, 64'(n), 64'd33);
    check({tag, "_state_done"}, 64'(dut.mdu_state), 64'(MDU_DONE));
    tick();
    check({tag, "_valid"}, 64'(valid_out), 64'd1);
    check({tag, "_result"}, 64'(Result_out), 64'(exp));
    check({tag, "_regwen"}, 64'(RegWEn_out), 64'd1);
    check({tag, "_addrd"}, 64'(AddrD_out), 64'd9);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    stall_in = 0;
    reset = 1;
    repeat (2) tick();
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_result", 64'(Result_out), 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_state", 64'(dut.mdu_state), 64'(MDU_IDLE));
    reset = 0;
    tick();

    // Forwarded A from MA plus immediate; B forwarded from WB onto DataB_out.
    valid_in = 1; RegWEn_in = 1; AddrD_in = 5'd3; ALUSel_in = ALU_ADD;
    DataA_in = 32'd5; fwd_ma_in = 32'd7; hazardSelA = FWD_MA; BSel_in = 1; imm_in = 32'd3;
    hazardSelB = FWD_WB; fwd_wb_in = 32'h1234; DataB_in = 32'h55; pcPlus4_in = 32'h104;
    tick();
    check("fwd_add_result", 64'(Result_out), 64'd10);
    check("fwd_add_valid", 64'(valid_out), 64'd1);
    check("fwd_add_datab", 64'(DataB_out), 64'h1234);
    check("fwd_add_pc4", 64'(pcPlus4_out), 64'h104);
    check("fwd_add_addrd", 64'(AddrD_out), 64'd3);

    // ASel picks pc; selector 3 falls back to the register value.
    idle_inputs();
    valid_in = 1; RegWEn_in = 1; ALUSel_in = ALU_SUB; ASel_in = 1; pc_in = 32'h100;
    hazardSelB = 2'd3; DataB_in = 32'h10; fwd_ma_in = 32'hFFFF; fwd_wb_in = 32'hEEEE;
    tick();
    check("asel_sub_result", 64'(Result_out), 64'hF0);

    // Bubble: valid_in low kills write enables.
    idle_inputs();
    RegWEn_in = 1; MemRW_in = 1;
    tick();
    check("bubble_valid", 64'(valid_out), 64'd0);
    check("bubble_regwen", 64'(RegWEn_out), 64'd0);
    check("bubble_memrw", 64'(MemRW_out), 64'd0);
    idle_inputs();

    run_mdu("mul",    F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_mdu("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_mdu("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_mdu("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_mdu("div_ovf", F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_mdu("rem_ovf", F3_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_mdu("divu_z", F3_DIVU,   32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    run_mdu("remu_z", F3_REMU,   32'd9, 32'd0, 32'd9, 0);
    run_mdu("div_z",  F3_DIV,    32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    run_mdu("rem_z",  F3_REM,    32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
    run_mdu("div_neg", F3_DIV,   32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 0);
    run_mdu("rem_neg", F3_REM,   32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 0);
    run_mdu("div_late", F3_DIV,  32'd100, 32'd7, 32'd14, 1);
    run_mdu("rem_late", F3_REM,  32'd100, 32'd7, 32'd2, 1);

    // Flush at RUN cycle 10.
    valid_in = 1; md_en_in = 1; funct3_in = F3_MUL; DataA_in = 32'd3; DataB_in = 32'd5; RegWEn_in = 1;
    repeat (10) tick();
    check("flush_pre_state", 64'(dut.mdu_state), 64'(MDU_RUN));
    flush_in = 1;
    #1;
    check("flush_stall_comb", 64'(stall_out), 64'd0);
    tick();
    idle_inputs();
    #1;
    check("flush_state", 64'(dut.mdu_state), 64'(MDU_IDLE));
    check("flush_stall", 64'(stall_out), 64'd0);
    check("flush_valid", 64'(valid_out), 64'd0);
    check("flush_regwen", 64'(RegWEn_out), 64'd0);
    valid_in = 1; RegWEn_in = 1; AddrD_in = 5'd4; DataA_in = 32'd20; DataB_in = 32'd22;
    tick();
    check("post_flush_add", 64'(Result_out), 64'd42);
    check("post_flush_valid", 64'(valid_out), 64'd1);

    // Stall on the ALU path: EX/MA holds.
    stall_in = 1; DataA_in = 32'd1; DataB_in = 32'd1;
    #1;
    check("alu_stall_out", 64'(stall_out), 64'd1);
    tick();
    check("alu_stall_hold", 64'(Result_out), 64'd42);
    stall_in = 0;
    tick();
    check("alu_stall_release", 64'(Result_out), 64'd2);
    idle_inputs();
    tick();

    // Stall held 3 cycles while the MDU sits in DONE.
    valid_in = 1; md_en_in = 1; funct3_in = F3_DIVU; DataA_in = 32'd50; DataB_in = 32'd5;
    RegWEn_in = 1; AddrD_in = 5'd7;
    repeat (33) tick();
    check("done_state", 64'(dut.mdu_state), 64'(MDU_DONE));
    stall_in = 1;
    #1;
    check("done_stall_forced", 64'(stall_out), 64'd1);
    repeat (3) begin
      tick();
      check("done_hold_valid", 64'(valid_out), 64'd0);
      check("done_hold_state", 64'(dut.mdu_state), 64'(MDU_DONE));
    end
    stall_in = 0;
    tick();
    check("done_release_valid", 64'(valid_out), 64'd1);
    check("done_release_result", 64'(Result_out), 64'd10);
    check("done_release_addrd", 64'(AddrD_out), 64'd7);
    idle_inputs();
    tick();

    // Reset at RUN cycle 5.
    valid_in = 1; md_en_in = 1; funct3_in = F3_MUL; DataA_in = 32'd3; DataB_in = 32'd5; RegWEn_in = 1;
    repeat (6) tick();
    reset = 1;
    #1;
    check("rrst_state", 64'(dut.mdu_state), 64'(MDU_IDLE));
    check("rrst_stall", 64'(stall_out), 64'd0);
    check("rrst_valid", 64'(valid_out), 64'd0);
    check("rrst_result", 64'(Result_out), 64'd0);
    check("rrst_addrd", 64'(AddrD_out), 64'd0);
    idle_inputs();
    tick();
    reset = 0;
    valid_in = 1; RegWEn_in = 1; ALUSel_in = ALU_SUB; DataA_in = 32'd7; DataB_in = 32'd2;
    tick();
    check("after_rst_sub", 64'(Result_out), 64'd5);
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
